// File: rtl/lbm_row_serializer.sv
// Row serializer for the lattice-row multiplexer: selects a source, captures its 2304-bit row,
// then streams it as 144 tagged 16-bit words over a valid/ready handshake.
module lbm_row_serializer #(
    parameter int unsigned DATA_WIDTH = 2304,
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned NUM_DIRS   = 9,
    parameter int unsigned NUM_CELLS  = 16,
    parameter int unsigned NUM_SRC    = 11
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         start,
    input  logic [3:0]                   src_sel,
    output logic [3:0]                   select,
    input  logic signed [DATA_WIDTH-1:0] Din,
    output logic signed [WORD_WIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [3:0]                   out_cell,
    output logic [3:0]                   out_dir,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLoad   = 2'd1;
    localparam logic [1:0] StStream = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    localparam logic [3:0] DirMax   = 4'(NUM_DIRS - 1);
    localparam logic [3:0] CellMax  = 4'(NUM_CELLS - 1);
    localparam logic [7:0] LastWord = 8'(NUM_CELLS * NUM_DIRS - 1);
    localparam logic [4:0] SrcLimit = 5'(NUM_SRC);

    logic [1:0]            state_q,  state_d;
    logic [3:0]            select_q, select_d;
    logic [DATA_WIDTH-1:0] row_q,    row_d;
    logic [3:0]            cell_q,   cell_d;
    logic [3:0]            dir_q,    dir_d;
    logic [7:0]            word_q,   word_d;
    logic                  err_q,    err_d;

    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        row_d    = row_q;
        cell_d   = cell_q;
        dir_d    = dir_q;
        word_d   = word_q;
        err_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if ({1'b0, src_sel} < SrcLimit) begin
                        select_d = src_sel;
                        state_d  = StLoad;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                // The mux is combinational and select has been stable for a full cycle.
                row_d   = Din;
                cell_d  = 4'd0;
                dir_d   = 4'd0;
                word_d  = 8'd0;
                state_d = StStream;
            end
            StStream: begin
                if (out_ready) begin
                    // The current word always sits in the low slot; shift the next one down.
                    row_d = {{WORD_WIDTH{1'b0}}, row_q[DATA_WIDTH-1:WORD_WIDTH]};
                    if (dir_q == DirMax) begin
                        dir_d  = 4'd0;
                        cell_d = cell_q + 4'd1;
                    end else begin
                        dir_d = dir_q + 4'd1;
                    end
                    if (word_q == LastWord) begin
                        word_d  = 8'd0;
                        state_d = StDone;
                    end else begin
                        word_d = word_q + 8'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q  <= StIdle;
            select_q <= 4'd0;
            row_q    <= '0;
            cell_q   <= 4'd0;
            dir_q    <= 4'd0;
            word_q   <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            row_q    <= row_d;
            cell_q   <= cell_d;
            dir_q    <= dir_d;
            word_q   <= word_d;
            err_q    <= err_d;
        end
    end

    assign select    = select_q;
    assign out_data  = row_q[WORD_WIDTH-1:0];
    assign out_valid = (state_q == StStream);
    assign out_cell  = cell_q;
    assign out_dir   = dir_q;
    assign out_last  = (state_q == StStream) && (cell_q == CellMax) && (dir_q == DirMax);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign err       = err_q;

endmodule

// File: tb/tb_lbm_row_serializer.sv
// Bench for lbm_row_serializer: request-handling vector table plus full-row streams checked
// against a word queue built from the row snapshot and the cell/direction layout rules.
module tb_lbm_row_serializer;

    localparam int DW = 2304;
    localparam int WW = 16;
    localparam int NW = 144;
    localparam int ND = 9;

    logic                 Clk = 1'b0;
    logic                 Reset_n;
    logic                 start;
    logic [3:0]           src_sel;
    logic [3:0]           select;
    logic signed [DW-1:0] Din;
    logic signed [WW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           out_cell;
    logic [3:0]           out_dir;
    logic                 out_last;
    logic                 busy;
    logic                 done;
    logic                 err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int row_start_cyc;
    int last_done_cyc;

    typedef struct {
        logic       start;
        logic [3:0] src;
        logic       exp_err;
        logic       exp_busy;
        logic [3:0] exp_sel;
    } vec_t;

    vec_t vecs[6];

    lbm_row_serializer dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .start    (start),
        .src_sel  (src_sel),
        .select   (select),
        .Din      (Din),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_cell (out_cell),
        .out_dir  (out_dir),
        .out_last (out_last),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_select"}, {28'd0, select}, 32'd0);
        chk({tag, "_data"}, {16'd0, out_data}, 32'd0);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_cell"}, {28'd0, out_cell}, 32'd0);
        chk({tag, "_dir"}, {28'd0, out_dir}, 32'd0);
        chk({tag, "_last"}, {31'd0, out_last}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < NW; i++) Din[i*WW +: WW] = 16'(i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < DW / 32; i++) Din[i*32 +: 32] = $urandom;
    endtask

    // mode: 0 = ready always high, 1 = ready pattern 1,0,0 repeating, 2 = random ready
    task automatic run_row(input logic [3:0] src, input int mode, input bit scribble,
                           input bit poke, input int reset_at, output int stream_cycles);
        logic [WW-1:0] exp_q[$];
        logic [DW-1:0] snap;
        int k;
        int cycles;
        bit r;
        snap = Din;
        for (int i = 0; i < NW; i++) exp_q.push_back(snap[i*WW +: WW]);

        start = 1'b1;
        src_sel = src;
        row_start_cyc = cyc;
        step();
        start = 1'b0;
        chk("load_select", {28'd0, select}, {28'd0, src});
        chk("load_busy", {31'd0, busy}, 32'd1);
        chk("load_valid", {31'd0, out_valid}, 32'd0);
        step();
        if (scribble) Din = '1;

        k = 0;
        cycles = 0;
        while (k < NW && cycles < 4 * NW) begin
            chk("valid", {31'd0, out_valid}, 32'd1);
            chk("data", {16'd0, out_data}, {16'd0, exp_q[k]});
            chk("cell", {28'd0, out_cell}, k / ND);
            chk("dir", {28'd0, out_dir}, k % ND);
            chk("last", {31'd0, out_last}, {31'd0, k == NW - 1});
            chk("stream_select", {28'd0, select}, {28'd0, src});
            chk("stream_done", {31'd0, done}, 32'd0);
            chk("stream_busy", {31'd0, busy}, 32'd1);
            if (k == reset_at) begin
                Reset_n = 1'b0;
                out_ready = 1'b1;
                step();
                Reset_n = 1'b1;
                check_idle_zero("mid_reset");
                stream_cycles = cycles;
                return;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (cycles % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            if (poke) begin
                start = (cycles % 5 == 2);
                src_sel = 4'd5;
            end
            out_ready = r;
            step();
            cycles++;
            if (r) k++;
        end
        start = 1'b0;
        chk("stream_complete", k, NW);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_valid", {31'd0, out_valid}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd1);
        last_done_cyc = cyc;
        step();
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_select", {28'd0, select}, {28'd0, src});
        stream_cycles = cycles;
    endtask

    initial begin
        int sc;
        int first_start;
        vecs[0] = '{start: 1'b1, src: 4'd11, exp_err: 1'b1, exp_busy: 1'b0, exp_sel: 4'd3};
        vecs[1] = '{start: 1'b0, src: 4'd0,  exp_err: 1'b0, exp_busy: 1'b0, exp_sel: 4'd3};
        vecs[2] = '{start: 1'b1, src: 4'd15, exp_err: 1'b1, exp_busy: 1'b0, exp_sel: 4'd3};
        vecs[3] = '{start: 1'b1, src: 4'd12, exp_err: 1'b1, exp_busy: 1'b0, exp_sel: 4'd3};
        vecs[4] = '{start: 1'b0, src: 4'd9,  exp_err: 1'b0, exp_busy: 1'b0, exp_sel: 4'd3};
        vecs[5] = '{start: 1'b1, src: 4'd13, exp_err: 1'b1, exp_busy: 1'b0, exp_sel: 4'd3};

        Reset_n = 1'b0;
        start = 1'b0;
        src_sel = 4'd0;
        out_ready = 1'b0;
        Din = '0;
        step();
        step();
        check_idle_zero("reset");
        Reset_n = 1'b1;
        step();
        check_idle_zero("post_reset");

        // Ramp row, ready held high: 144 consecutive words.
        fill_ramp();
        run_row(4'd3, 0, 1'b0, 1'b0, -1, sc);
        chk("row_cycles", sc, NW);

        // Illegal requests from IDLE.
        for (int i = 0; i < 6; i++) begin
            start = vecs[i].start;
            src_sel = vecs[i].src;
            step();
            chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
            chk($sformatf("vec%0d_select", i), {28'd0, select}, {28'd0, vecs[i].exp_sel});
        end
        start = 1'b0;
        step();
        chk("err_clear", {31'd0, err}, 32'd0);

        // Stalling consumer, Din overwritten after capture.
        fill_ramp();
        run_row(4'd3, 1, 1'b1, 1'b0, -1, sc);

        // Start pulses during streaming are ignored.
        fill_random();
        run_row(4'd7, 0, 1'b0, 1'b1, -1, sc);

        // Reset mid-stream, then a fresh row.
        fill_ramp();
        run_row(4'd2, 0, 1'b0, 1'b0, 70, sc);
        run_row(4'd10, 0, 1'b0, 1'b0, -1, sc);

        // Back-to-back rows.
        fill_random();
        out_ready = 1'b1;
        run_row(4'd0, 0, 1'b0, 1'b0, -1, sc);
        first_start = row_start_cyc;
        run_row(4'd0, 0, 1'b0, 1'b0, -1, sc);
        chk("b2b_cycles", last_done_cyc - first_start + 1, 2 * 147);

        // Random rows, sources and ready.
        for (int i = 0; i < 4; i++) begin
            fill_random();
            run_row(4'($urandom_range(0, 10)), 2, 1'($urandom_range(0, 1)), 1'b0, -1, sc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
